// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Encodes instruction symbols into 32-bit machine words, assigns
//               sequential byte addresses and buffers results in a 2-entry
//               FIFO. Define INSTR_ENCODER_COP0_EN to add MFC0/MTC0/ERET.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int WIDTH_INSTR = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH_INSTR-1:0] in_instr,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_shamt,
  input  logic [15:0]            in_imm,
  input  logic [25:0]            in_jmpaddr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_code,
  output logic [31:0]            out_addr,
  output logic                   out_err,
  output logic [15:0]            err_cnt
);

  // Symbol codes shared with the instruction producer; values >= 64 are undefined.
  localparam logic [WIDTH_INSTR-1:0] SYM_NOP   = 0,  SYM_ADD   = 1,  SYM_ADDU  = 2,  SYM_SUB   = 3;
  localparam logic [WIDTH_INSTR-1:0] SYM_SUBU  = 4,  SYM_AND   = 5,  SYM_OR    = 6,  SYM_XOR   = 7;
  localparam logic [WIDTH_INSTR-1:0] SYM_NOR   = 8,  SYM_SLT   = 9,  SYM_SLTU  = 10, SYM_SLL   = 11;
  localparam logic [WIDTH_INSTR-1:0] SYM_SRL   = 12, SYM_SRA   = 13, SYM_SLLV  = 14, SYM_SRLV  = 15;
  localparam logic [WIDTH_INSTR-1:0] SYM_SRAV  = 16, SYM_JR    = 17, SYM_JALR  = 18, SYM_MULT  = 19;
  localparam logic [WIDTH_INSTR-1:0] SYM_MULTU = 20, SYM_DIV   = 21, SYM_DIVU  = 22, SYM_MFHI  = 23;
  localparam logic [WIDTH_INSTR-1:0] SYM_MFLO  = 24, SYM_MTHI  = 25, SYM_MTLO  = 26, SYM_MOVZ  = 27;
  localparam logic [WIDTH_INSTR-1:0] SYM_MOVN  = 28, SYM_ADDI  = 29, SYM_ADDIU = 30, SYM_SLTI  = 31;
  localparam logic [WIDTH_INSTR-1:0] SYM_SLTIU = 32, SYM_ANDI  = 33, SYM_ORI   = 34, SYM_XORI  = 35;
  localparam logic [WIDTH_INSTR-1:0] SYM_LUI   = 36, SYM_LB    = 37, SYM_LBU   = 38, SYM_LH    = 39;
  localparam logic [WIDTH_INSTR-1:0] SYM_LHU   = 40, SYM_LW    = 41, SYM_SB    = 42, SYM_SH    = 43;
  localparam logic [WIDTH_INSTR-1:0] SYM_SW    = 44, SYM_BEQ   = 45, SYM_BNE   = 46, SYM_BLEZ  = 47;
  localparam logic [WIDTH_INSTR-1:0] SYM_BGTZ  = 48, SYM_BLTZ  = 49, SYM_BGEZ  = 50, SYM_BLTZAL = 51;
  localparam logic [WIDTH_INSTR-1:0] SYM_BGEZAL = 52, SYM_J    = 53, SYM_JAL   = 54, SYM_CLZ   = 55;
  localparam logic [WIDTH_INSTR-1:0] SYM_CLO   = 56, SYM_MADD  = 57, SYM_MADDU = 58, SYM_MSUB  = 59;
  localparam logic [WIDTH_INSTR-1:0] SYM_MSUBU = 60;
`ifdef INSTR_ENCODER_COP0_EN
  localparam logic [WIDTH_INSTR-1:0] SYM_MFC0  = 61, SYM_MTC0  = 62, SYM_ERET  = 63;
`endif

  localparam logic [31:0] ADDR_START = 32'h0000_3000;

  logic [31:0] r_base;
  logic [31:0] enc_code;
  logic        enc_err;

  assign r_base = {6'd0, in_rs, in_rt, in_rd, 11'd0};

  always_comb begin
    enc_code = 32'd0;
    enc_err  = 1'b0;
    case (in_instr)
      SYM_NOP:    enc_code = 32'd0;
      SYM_ADD:    enc_code = r_base | 32'h20;
      SYM_ADDU:   enc_code = r_base | 32'h21;
      SYM_SUB:    enc_code = r_base | 32'h22;
      SYM_SUBU:   enc_code = r_base | 32'h23;
      SYM_AND:    enc_code = r_base | 32'h24;
      SYM_OR:     enc_code = r_base | 32'h25;
      SYM_XOR:    enc_code = r_base | 32'h26;
      SYM_NOR:    enc_code = r_base | 32'h27;
      SYM_SLT:    enc_code = r_base | 32'h2a;
      SYM_SLTU:   enc_code = r_base | 32'h2b;
      SYM_SLL:    enc_code = r_base | {21'd0, in_shamt, 6'h00};
      SYM_SRL:    enc_code = r_base | {21'd0, in_shamt, 6'h02};
      SYM_SRA:    enc_code = r_base | {21'd0, in_shamt, 6'h03};
      SYM_SLLV:   enc_code = r_base | 32'h04;
      SYM_SRLV:   enc_code = r_base | 32'h06;
      SYM_SRAV:   enc_code = r_base | 32'h07;
      SYM_JR:     enc_code = r_base | 32'h08;
      SYM_JALR:   enc_code = r_base | 32'h09;
      SYM_MOVZ:   enc_code = r_base | 32'h0a;
      SYM_MOVN:   enc_code = r_base | 32'h0b;
      SYM_MFHI:   enc_code = r_base | 32'h10;
      SYM_MTHI:   enc_code = r_base | 32'h11;
      SYM_MFLO:   enc_code = r_base | 32'h12;
      SYM_MTLO:   enc_code = r_base | 32'h13;
      SYM_MULT:   enc_code = r_base | 32'h18;
      SYM_MULTU:  enc_code = r_base | 32'h19;
      SYM_DIV:    enc_code = r_base | 32'h1a;
      SYM_DIVU:   enc_code = r_base | 32'h1b;
      SYM_ADDI:   enc_code = {6'h08, in_rs, in_rt, in_imm};
      SYM_ADDIU:  enc_code = {6'h09, in_rs, in_rt, in_imm};
      SYM_SLTI:   enc_code = {6'h0a, in_rs, in_rt, in_imm};
      SYM_SLTIU:  enc_code = {6'h0b, in_rs, in_rt, in_imm};
      SYM_ANDI:   enc_code = {6'h0c, in_rs, in_rt, in_imm};
      SYM_ORI:    enc_code = {6'h0d, in_rs, in_rt, in_imm};
      SYM_XORI:   enc_code = {6'h0e, in_rs, in_rt, in_imm};
      SYM_LUI:    enc_code = {6'h0f, 5'd0,  in_rt, in_imm};
      SYM_LB:     enc_code = {6'h20, in_rs, in_rt, in_imm};
      SYM_LH:     enc_code = {6'h21, in_rs, in_rt, in_imm};
      SYM_LW:     enc_code = {6'h23, in_rs, in_rt, in_imm};
      SYM_LBU:    enc_code = {6'h24, in_rs, in_rt, in_imm};
      SYM_LHU:    enc_code = {6'h25, in_rs, in_rt, in_imm};
      SYM_SB:     enc_code = {6'h28, in_rs, in_rt, in_imm};
      SYM_SH:     enc_code = {6'h29, in_rs, in_rt, in_imm};
      SYM_SW:     enc_code = {6'h2b, in_rs, in_rt, in_imm};
      SYM_BEQ:    enc_code = {6'h04, in_rs, in_rt, in_imm};
      SYM_BNE:    enc_code = {6'h05, in_rs, in_rt, in_imm};
      SYM_BLEZ:   enc_code = {6'h06, in_rs, 5'd0,  in_imm};
      SYM_BGTZ:   enc_code = {6'h07, in_rs, 5'd0,  in_imm};
      // REGIMM branches select the condition through the rt field
      SYM_BLTZ:   enc_code = {6'h01, in_rs, 5'h00, in_imm};
      SYM_BGEZ:   enc_code = {6'h01, in_rs, 5'h01, in_imm};
      SYM_BLTZAL: enc_code = {6'h01, in_rs, 5'h10, in_imm};
      SYM_BGEZAL: enc_code = {6'h01, in_rs, 5'h11, in_imm};
      SYM_J:      enc_code = {6'h02, in_jmpaddr};
      SYM_JAL:    enc_code = {6'h03, in_jmpaddr};
      SYM_CLZ:    enc_code = {6'h1c, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      SYM_CLO:    enc_code = {6'h1c, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      SYM_MADD:   enc_code = {6'h1c, in_rs, in_rt, in_rd, 5'd0, 6'h00};
      SYM_MADDU:  enc_code = {6'h1c, in_rs, in_rt, in_rd, 5'd0, 6'h01};
      SYM_MSUB:   enc_code = {6'h1c, in_rs, in_rt, in_rd, 5'd0, 6'h04};
      SYM_MSUBU:  enc_code = {6'h1c, in_rs, in_rt, in_rd, 5'd0, 6'h05};
`ifdef INSTR_ENCODER_COP0_EN
      SYM_MFC0:   enc_code = {6'h10, 5'h00, in_rt, in_rd, 11'd0};
      SYM_MTC0:   enc_code = {6'h10, 5'h04, in_rt, in_rd, 11'd0};
      SYM_ERET:   enc_code = 32'h4200_0018;
`endif
      default:    enc_err  = 1'b1;
    endcase
  end

  logic [31:0] mem_code [2];
  logic [31:0] mem_addr [2];
  logic        mem_err  [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [31:0] addr_cnt;
  logic        push;
  logic        pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count > 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_code  = mem_code[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];
  assign out_err   = mem_err[rd_ptr];

  // Entries are cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_code[0] <= 32'd0;
      mem_code[1] <= 32'd0;
      mem_addr[0] <= 32'd0;
      mem_addr[1] <= 32'd0;
      mem_err[0]  <= 1'b0;
      mem_err[1]  <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      addr_cnt    <= ADDR_START;
      err_cnt     <= 16'd0;
    end else begin
      if (push) begin
        mem_code[wr_ptr] <= enc_code;
        mem_addr[wr_ptr] <= addr_cnt;
        mem_err[wr_ptr]  <= enc_err;
        wr_ptr           <= ~wr_ptr;
        addr_cnt         <= addr_cnt + 32'd4;
        if (enc_err && (err_cnt != 16'hFFFF)) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (both INSTR_ENCODER_COP0_EN builds).
`default_nettype none

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_instr = 7'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
  logic [15:0] in_imm = 16'd0;
  logic [25:0] in_jmpaddr = 26'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_code;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S_NOP = 0, S_ADD = 1, S_ADDU = 2, S_SLL = 11, S_ORI = 34, S_LUI = 36;
  localparam logic [6:0] S_SW = 44, S_BLEZ = 47, S_BGEZ = 50, S_BLTZAL = 51, S_J = 53, S_JAL = 54;
  localparam logic [6:0] S_MADDU = 58, S_MFC0 = 61, S_ERET = 63, S_UNDEF = 100;

  instr_encoder #(.WIDTH_INSTR(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .in_jmpaddr (in_jmpaddr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] sym, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] jmp);
    in_instr   = sym;
    in_rs      = rs;
    in_rt      = rt;
    in_rd      = rd;
    in_shamt   = sh;
    in_imm     = imm;
    in_jmpaddr = jmp;
    in_valid   = 1'b1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
  endtask

  // Push one request with out_ready high and check the word it produces.
  task automatic one(input string tag, input logic [6:0] sym, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                     input logic [15:0] imm, input logic [25:0] jmp, input logic [31:0] exp_code,
                     input logic [31:0] exp_addr);
    drive(sym, rs, rt, rd, sh, imm, jmp);
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_code"}, out_code, exp_code);
    chk({tag, "_addr"}, out_addr, exp_addr);
    chk({tag, "_err"}, {31'd0, out_err}, 32'd0);
  endtask

  initial begin
    // Reset with a pending request that must be ignored
    in_valid = 1'b1;
    in_instr = S_ADDU;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_code", out_code, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    do_reset();

    out_ready = 1'b1;
    one("addu", S_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'h0022_1821, 32'h0000_3000);
    tick();
    chk("addu_drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream after a fresh reset
    do_reset();
    one("ori", S_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, 32'h3401_1234, 32'h3000);
    one("bgez", S_BGEZ, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0010, 26'd0, 32'h0481_0010, 32'h3004);
    one("jal", S_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000C00, 32'h0C00_0C00, 32'h3008);
    one("sll", S_SLL, 5'd0, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0, 32'h0002_1900, 32'h300C);
    one("add_shamt0", S_ADD, 5'd1, 5'd2, 5'd3, 5'd5, 16'd0, 26'd0, 32'h0022_1820, 32'h3010);
    one("blez_rt0", S_BLEZ, 5'd3, 5'd7, 5'd0, 5'd0, 16'hFFFF, 26'd0, 32'h1860_FFFF, 32'h3014);
    one("lui_rs0", S_LUI, 5'd9, 5'd4, 5'd0, 5'd0, 16'hABCD, 26'd0, 32'h3C04_ABCD, 32'h3018);
    one("bltzal", S_BLTZAL, 5'd2, 5'd0, 5'd0, 5'd0, 16'h0008, 26'd0, 32'h0450_0008, 32'h301C);
    one("maddu", S_MADDU, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, 26'd0, 32'h7022_0001, 32'h3020);
    one("sw", S_SW, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 26'd0, 32'hAFBF_0004, 32'h3024);
    one("j", S_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FF_FFFF, 32'h0BFF_FFFF, 32'h3028);
    tick();
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Undefined symbol: zero code, error flag, counted, address still advances
    do_reset();
    drive(S_UNDEF, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    tick();
    in_valid = 1'b0;
    chk("undef_code", out_code, 32'd0);
    chk("undef_err", {31'd0, out_err}, 32'd1);
    chk("undef_cnt", {16'd0, err_cnt}, 32'd1);
    chk("undef_addr", out_addr, 32'h3000);
    one("nop_after", S_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'd0, 32'h3004);
    chk("nop_cnt", {16'd0, err_cnt}, 32'd1);
    tick();

    // Backpressure: third request ignored while full, then drain in order
    do_reset();
    out_ready = 1'b0;
    drive(S_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    tick();
    chk("bp_ready_1", {31'd0, in_ready}, 32'd1);
    drive(S_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0);
    tick();
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    drive(S_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FF_FFFF);
    tick();
    in_valid = 1'b0;
    chk("bp_head_code", out_code, 32'h0022_1821);
    chk("bp_head_addr", out_addr, 32'h3000);
    out_ready = 1'b1;
    tick();
    chk("bp_2nd_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_2nd_code", out_code, 32'h3401_1234);
    chk("bp_2nd_addr", out_addr, 32'h3004);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    one("bp_next", S_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'd0, 32'h3008);
    tick();

    // Reset while full discards contents and restarts the address counter
    do_reset();
    out_ready = 1'b0;
    drive(S_UNDEF, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    tick();
    drive(S_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    tick();
    chk("full_cnt", {16'd0, err_cnt}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rstfull_valid", {31'd0, out_valid}, 32'd0);
    chk("rstfull_ready", {31'd0, in_ready}, 32'd1);
    chk("rstfull_cnt", {16'd0, err_cnt}, 32'd0);
    out_ready = 1'b1;
    one("rstfull_next", S_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'd0, 32'h3000);
    tick();

    // Coprocessor-0 symbols depend on the build option
    do_reset();
`ifdef INSTR_ENCODER_COP0_EN
    one("mfc0", S_MFC0, 5'd0, 5'd2, 5'd12, 5'd0, 16'd0, 26'd0, 32'h4002_6000, 32'h3000);
    one("eret", S_ERET, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'h4200_0018, 32'h3004);
    chk("cop0_cnt", {16'd0, err_cnt}, 32'd0);
`else
    drive(S_MFC0, 5'd0, 5'd2, 5'd12, 5'd0, 16'd0, 26'd0);
    tick();
    chk("mfc0_code", out_code, 32'd0);
    chk("mfc0_err", {31'd0, out_err}, 32'd1);
    drive(S_ERET, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    tick();
    in_valid = 1'b0;
    chk("eret_err", {31'd0, out_err}, 32'd1);
    chk("eret_addr", out_addr, 32'h3004);
    chk("cop0_cnt", {16'd0, err_cnt}, 32'd2);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
